// File: rtl/rts_trip_pkg.sv
// Shared types and helpers for the RTS channel trip unit.
//   mode_t  : per-channel operating mode (RESERVED behaves as MANUAL_TRIP)
//   sat_add : unsigned add, saturating at 2^w-1
//   sat_sub : unsigned subtract, saturating at 0
package rts_trip_pkg;

  typedef enum logic [1:0] {
    BYPASS      = 2'd0,
    OPERATE     = 2'd1,
    MANUAL_TRIP = 2'd2,
    RESERVED    = 2'd3
  } mode_t;

  // Widest sample width the helpers support.
  localparam int unsigned MaxWidth = 64;

  // Add with one guard bit, then clamp to the all-ones value of a w-bit word.
  function automatic logic [MaxWidth-1:0] sat_add(input logic [MaxWidth-1:0] a,
                                                  input logic [MaxWidth-1:0] b,
                                                  input int unsigned        w);
    logic [MaxWidth:0] sum;
    logic [MaxWidth:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = ((MaxWidth+1)'(1) << w) - (MaxWidth+1)'(1);
    return (sum > lim) ? lim[MaxWidth-1:0] : sum[MaxWidth-1:0];
  endfunction

  function automatic logic [MaxWidth-1:0] sat_sub(input logic [MaxWidth-1:0] a,
                                                  input logic [MaxWidth-1:0] b);
    return (a >= b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/rts_trip_if.sv
// Sample/setpoint bus into the trip unit and trip status back out.
// Channel 0 occupies the MSB slice of every packed vector.
//   master : sample source / operator side
//   slave  : the trip unit
interface rts_trip_if #(
  parameter int unsigned NChannels = 3,
  parameter int unsigned Width     = 32
);

  logic                         sample_valid;
  logic [NChannels*Width-1:0]   vals;
  logic [NChannels*Width-1:0]   setpoints;
  logic [Width-1:0]             hysteresis;
  logic [NChannels-1:0]         trip_below;
  logic [2*NChannels-1:0]       mode;
  logic [NChannels-1:0]         reset_trip;
  logic [NChannels-1:0]         sensor_tripped;
  logic [NChannels-1:0]         trip;
  logic                         out_valid;

  modport master (
    output sample_valid, vals, setpoints, hysteresis, trip_below, mode, reset_trip,
    input  sensor_tripped, trip, out_valid
  );

  modport slave (
    input  sample_valid, vals, setpoints, hysteresis, trip_below, mode, reset_trip,
    output sensor_tripped, trip, out_valid
  );

endinterface

// File: rtl/rts_trip_channel.sv
// One channel: strict compare, debounce counter, hysteresis clear and trip latch.
//   val/setpoint/hyst : unsigned sample, setpoint, shared clear margin
//   trip_below        : 1 = trip when val < setpoint, 0 = val > setpoint
//   mode              : BYPASS / OPERATE / MANUAL_TRIP / RESERVED
//   reset_trip        : operator latch reset (level)
//   sensor_tripped    : registered debounced sensor state
//   trip              : latch masked by bypass (combinational on mode)
module rts_trip_channel
  import rts_trip_pkg::*;
#(
  parameter int unsigned Width         = 32,
  parameter int unsigned DebounceDepth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_valid,
  input  logic [Width-1:0] val,
  input  logic [Width-1:0] setpoint,
  input  logic [Width-1:0] hyst,
  input  logic             trip_below,
  input  mode_t            mode,
  input  logic             reset_trip,
  output logic             sensor_tripped,
  output logic             trip
);

  localparam int unsigned     CntW   = $clog2(DebounceDepth + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceDepth);

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             st_d;
  logic             latch_q, latch_d;
  logic             exceed_c, clear_c, set_c;
  logic [Width-1:0] lo_c, hi_c;

  // Exceed/clear thresholds; the clear band edges saturate at the word limits.
  always_comb begin
    lo_c     = Width'(sat_sub(MaxWidth'(setpoint), MaxWidth'(hyst)));
    hi_c     = Width'(sat_add(MaxWidth'(setpoint), MaxWidth'(hyst), Width));
    exceed_c = trip_below ? (val < setpoint) : (val > setpoint);
    clear_c  = trip_below ? (val >= hi_c) : (val <= lo_c);
  end

  // Debounce and latch next-state.
  always_comb begin
    cnt_d = cnt_q;
    st_d  = sensor_tripped;
    if (sample_valid) begin
      if (exceed_c) begin
        cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
      end else begin
        cnt_d = '0;
      end
      if (cnt_d == CntMax) begin
        st_d = 1'b1;
      end else if (clear_c) begin
        st_d = 1'b0;
      end
    end
    // Latch sees the registered sensor state; set dominates reset.
    set_c   = (mode == MANUAL_TRIP) || (mode == RESERVED) ||
              ((mode == OPERATE) && sensor_tripped);
    latch_d = set_c | (latch_q & ~reset_trip);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      sensor_tripped <= 1'b0;
      latch_q        <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      sensor_tripped <= st_d;
      latch_q        <= latch_d;
    end
  end

  // Bypass hides the latch without clearing it.
  assign trip = latch_q & (mode != BYPASS);

endmodule

// File: rtl/rts_trip_unit.sv
// RTS channel trip unit: NChannels independent trip channels plus a sample
// acknowledge strobe.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : rts_trip_if slave (samples, setpoints, modes in; trip status out)
module rts_trip_unit
  import rts_trip_pkg::*;
#(
  parameter int unsigned NChannels     = 3,
  parameter int unsigned Width         = 32,
  parameter int unsigned DebounceDepth = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  rts_trip_if.slave  bus
);

  logic [NChannels-1:0] st_w;
  logic [NChannels-1:0] trip_w;
  logic                 ov_q;

  // Channel c lives in slice NChannels-c-1 of every packed vector.
  for (genvar c = 0; c < NChannels; c++) begin : g_ch
    localparam int unsigned Idx = NChannels - c - 1;
    rts_trip_channel #(
      .Width         (Width),
      .DebounceDepth (DebounceDepth)
    ) u_ch (
      .clk            (clk),
      .rst_n          (rst_n),
      .sample_valid   (bus.sample_valid),
      .val            (bus.vals[Width*Idx +: Width]),
      .setpoint       (bus.setpoints[Width*Idx +: Width]),
      .hyst           (bus.hysteresis),
      .trip_below     (bus.trip_below[Idx]),
      .mode           (mode_t'(bus.mode[2*Idx +: 2])),
      .reset_trip     (bus.reset_trip[Idx]),
      .sensor_tripped (st_w[Idx]),
      .trip           (trip_w[Idx])
    );
  end

  // One-cycle acknowledge per accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q <= 1'b0;
    end else begin
      ov_q <= bus.sample_valid;
    end
  end

  assign bus.sensor_tripped = st_w;
  assign bus.trip           = trip_w;
  assign bus.out_valid      = ov_q;

endmodule

// File: tb/tb_rts_trip_unit.sv
// Directed bench for rts_trip_unit with a per-cycle reference model.
module tb_rts_trip_unit;

  localparam int unsigned N = 3;
  localparam int unsigned W = 32;
  localparam int unsigned D = 4;
  localparam longint      MaxV = 64'h0000_0000_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rts_trip_if #(.NChannels(N), .Width(W)) bus ();

  rts_trip_unit #(.NChannels(N), .Width(W), .DebounceDepth(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests    = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Reference state: length of the current run of exceeding samples,
  // debounced sensor state and the operator latch per channel.
  int run_m   [N];
  bit st_m    [N];
  bit latch_m [N];
  bit ov_m;

  initial begin
    for (int c = 0; c < N; c++) begin
      run_m[c] = 0; st_m[c] = 1'b0; latch_m[c] = 1'b0;
    end
    ov_m = 1'b0;
  end

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N; c++) begin
        run_m[c] = 0; st_m[c] = 1'b0; latch_m[c] = 1'b0;
      end
      ov_m = 1'b0;
    end else begin
      for (int c = 0; c < N; c++) begin
        logic [1:0] md;
        longint     v, sp, h, lo, hi;
        bit         below, exc, clr;
        md = bus.mode[2*(N-1-c) +: 2];
        // Latch reacts to the sensor state as it stood before this edge.
        if (md >= 2'd2 || (md == 2'd1 && st_m[c])) latch_m[c] = 1'b1;
        else if (bus.reset_trip[N-1-c]) latch_m[c] = 1'b0;
        if (bus.sample_valid) begin
          v     = 64'(bus.vals[W*(N-1-c) +: W]);
          sp    = 64'(bus.setpoints[W*(N-1-c) +: W]);
          h     = 64'(bus.hysteresis);
          below = bus.trip_below[N-1-c];
          lo    = (sp > h) ? sp - h : 0;
          hi    = (sp + h > MaxV) ? MaxV : sp + h;
          exc   = below ? (v < sp) : (v > sp);
          clr   = below ? (v >= hi) : (v <= lo);
          run_m[c] = exc ? run_m[c] + 1 : 0;
          if (run_m[c] >= D) st_m[c] = 1'b1;
          else if (clr) st_m[c] = 1'b0;
        end
      end
      ov_m = bus.sample_valid;
    end
  end

  // Compare DUT against the model on every falling edge once out of reset.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [N-1:0] e_st, e_tr;
      for (int c = 0; c < N; c++) begin
        e_st[N-1-c] = st_m[c];
        e_tr[N-1-c] = latch_m[c] && (bus.mode[2*(N-1-c) +: 2] != 2'b00);
      end
      check("model_sensor_tripped", bus.sensor_tripped, e_st);
      check("model_trip", bus.trip, e_tr);
      check("model_out_valid", N'(bus.out_valid), N'(ov_m));
    end
  end

  task automatic set_val(input int c, input logic [W-1:0] v);
    bus.vals[W*(N-1-c) +: W] = v;
  endtask

  task automatic set_sp(input int c, input logic [W-1:0] v);
    bus.setpoints[W*(N-1-c) +: W] = v;
  endtask

  task automatic set_mode(input int c, input logic [1:0] m);
    bus.mode[2*(N-1-c) +: 2] = m;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sample(input logic [W-1:0] v0, input logic [W-1:0] v1, input logic [W-1:0] v2);
    set_val(0, v0); set_val(1, v1); set_val(2, v2);
    bus.sample_valid = 1'b1;
    tick(1);
    bus.sample_valid = 1'b0;
  endtask

  // Channel 0 sample with channels 1/2 parked at non-exceeding values.
  task automatic s0(input logic [W-1:0] v0);
    sample(v0, 32'd0, 32'd100);
  endtask

  task automatic pulse_reset(input logic [N-1:0] r);
    bus.reset_trip = r;
    tick(1);
    bus.reset_trip = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    rst_n            = 1'b0;
    bus.sample_valid = 1'b0;
    bus.vals         = '0;
    bus.setpoints    = '0;
    bus.hysteresis   = 32'd10;
    bus.trip_below   = 3'b001;
    bus.mode         = 6'b01_01_01;
    bus.reset_trip   = '0;
    set_sp(0, 32'd100); set_sp(1, 32'd1000); set_sp(2, 32'd50);
    set_val(2, 32'd100);
    tick(2);
    check("reset_sensor_tripped", bus.sensor_tripped, 3'b000);
    check("reset_trip", bus.trip, 3'b000);
    check("reset_out_valid", N'(bus.out_valid), 3'b000);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    tick(1);

    // 1: debounce above setpoint; an in-band sample breaks the run.
    repeat (3) s0(32'd101);
    s0(32'd100);
    check("t1_band_no_trip", bus.sensor_tripped, 3'b000);
    repeat (3) s0(32'd101);
    check("t1_run_restarted", bus.sensor_tripped, 3'b000);
    s0(32'd101);
    check("t1_sensor_set", bus.sensor_tripped, 3'b100);
    check("t1_trip_lags", bus.trip, 3'b000);
    check("t1_out_valid", N'(bus.out_valid), 3'b001);
    tick(1);
    check("t1_trip_set", bus.trip, 3'b100);
    check("t1_out_valid_pulse", N'(bus.out_valid), 3'b000);

    // 2: hysteresis and latch behaviour.
    s0(32'd95);
    check("t2_band_hold", bus.sensor_tripped, 3'b100);
    s0(32'd90);
    check("t2_clear", bus.sensor_tripped, 3'b000);
    check("t2_latch_holds", bus.trip, 3'b100);
    pulse_reset(3'b100);
    check("t2_reset_clears", bus.trip, 3'b000);
    repeat (4) s0(32'd101);
    tick(1);
    bus.reset_trip = 3'b100;
    tick(2);
    check("t2_set_wins", bus.trip, 3'b100);
    bus.reset_trip = '0;
    s0(32'd90);
    pulse_reset(3'b100);
    check("t2_cleanup", bus.trip, 3'b000);

    // 3: below-direction channel 2.
    repeat (5) sample(32'd0, 32'd0, 32'd50);
    check("t3_equal_no_trip", bus.sensor_tripped, 3'b000);
    repeat (4) sample(32'd0, 32'd0, 32'd49);
    check("t3_sensor_set", bus.sensor_tripped, 3'b001);
    tick(1);
    check("t3_trip_only_ch2", bus.trip, 3'b001);
    sample(32'd0, 32'd0, 32'd55);
    check("t3_band_hold", bus.sensor_tripped, 3'b001);
    sample(32'd0, 32'd0, 32'd60);
    check("t3_clear", bus.sensor_tripped, 3'b000);
    pulse_reset(3'b001);
    check("t3_cleanup", bus.trip, 3'b000);

    // 4: saturating thresholds.
    set_sp(0, 32'd5);
    repeat (4) s0(32'd6);
    check("t4_sensor_set", bus.sensor_tripped, 3'b100);
    s0(32'd1);
    check("t4_sat_sub_hold", bus.sensor_tripped, 3'b100);
    s0(32'd0);
    check("t4_sat_sub_clear", bus.sensor_tripped, 3'b000);
    pulse_reset(3'b100);
    check("t4_cleanup", bus.trip, 3'b000);
    set_sp(0, 32'hFFFF_FFFF);
    repeat (5) s0(32'hFFFF_FFFF);
    tick(1);
    check("t4_max_no_trip_st", bus.sensor_tripped, 3'b000);
    check("t4_max_no_trip", bus.trip, 3'b000);
    set_sp(2, 32'hFFFF_FFF8);
    repeat (4) sample(32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFF0);
    check("t4_below_set", bus.sensor_tripped, 3'b001);
    sample(32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFE);
    check("t4_sat_add_hold", bus.sensor_tripped, 3'b001);
    sample(32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF);
    check("t4_sat_add_clear", bus.sensor_tripped, 3'b000);
    pulse_reset(3'b001);
    set_sp(0, 32'd100);
    set_sp(2, 32'd50);
    set_val(2, 32'd100);
    tick(1);
    check("t4_restore", bus.trip, 3'b000);

    // 5: modes without samples.
    set_mode(1, 2'd2);
    #1;
    check("t5_manual_not_instant", bus.trip, 3'b000);
    tick(1);
    check("t5_manual_trip", bus.trip, 3'b010);
    set_mode(2, 2'd3);
    tick(1);
    check("t5_reserved_trip", bus.trip, 3'b011);
    set_mode(1, 2'd1); set_mode(2, 2'd1);
    tick(1);
    check("t5_latch_holds", bus.trip, 3'b011);
    set_mode(1, 2'd0);
    #1;
    check("t5_bypass_masks", bus.trip, 3'b001);
    tick(2);
    check("t5_bypass_keeps_masked", bus.trip, 3'b001);
    set_mode(1, 2'd1);
    #1;
    check("t5_unbypass_reexposes", bus.trip, 3'b011);
    pulse_reset(3'b011);
    check("t5_reset_clears", bus.trip, 3'b000);

    // 6: reset mid-debounce discards partial counts.
    repeat (3) s0(32'd101);
    rst_n = 1'b0;
    #1;
    check("t6_async_reset_st", bus.sensor_tripped, 3'b000);
    check("t6_async_reset_ov", N'(bus.out_valid), 3'b000);
    tick(1);
    rst_n = 1'b1;
    s0(32'd101);
    check("t6_partial_discarded", bus.sensor_tripped, 3'b000);
    tick(1);
    check("t6_no_trip", bus.trip, 3'b000);
    repeat (4) s0(32'd101);
    check("t6_sensor_set", bus.sensor_tripped, 3'b100);
    check("t6_trip_set", bus.trip, 3'b100);
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
